// File: rtl/stepper_axis_driver.sv
// Two-axis full-step stepper driver for the solar tracker: a shared step-rate prescaler
// feeds two independent axis FSMs that return each axis position in degrees.

module stepper_axis #(
  parameter int STEPS_PER_DEG = 8,
  parameter int SETTLE_TICKS  = 2,
  parameter int ANGLE_MAX     = 360
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tick,
  input  logic [1:0]  cmd,
  output logic [3:0]  coil,
  output logic [15:0] angle,
  output logic        moving
);
  // state  | meaning
  // IDLE   | coils hold current phase, no motion
  // FWD    | stepping forward (angle up) on each tick
  // REV    | stepping in reverse (angle down) on each tick
  // SETTLE | forced idle ticks before a direction reversal
  typedef enum logic [1:0] {S_IDLE, S_FWD, S_REV, S_SETTLE} axis_state_t;

  localparam int SUB_W = (STEPS_PER_DEG > 1) ? $clog2(STEPS_PER_DEG) : 1;
  localparam int SET_W = $clog2(SETTLE_TICKS + 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(STEPS_PER_DEG - 1);
  localparam logic [SET_W-1:0] SET_LOAD   = SET_W'(SETTLE_TICKS);
  localparam logic [SET_W-1:0] SET_ONE    = SET_W'(1);
  localparam logic [15:0]      ANGLE_LAST = 16'(ANGLE_MAX - 1);

  axis_state_t      state, state_nxt;
  logic [1:0]       phase, phase_nxt;
  logic [SUB_W-1:0] sub, sub_nxt;
  logic [SET_W-1:0] settle, settle_nxt;
  logic [15:0]      angle_nxt;
  logic [3:0]       coil_nxt;
  logic             step_fwd, step_rev;
  logic             cmd_fwd, cmd_rev;

  function automatic logic [3:0] coil_map(input logic [1:0] ph);
    case (ph)
      2'd0:    coil_map = 4'b1100;
      2'd1:    coil_map = 4'b0110;
      2'd2:    coil_map = 4'b0011;
      default: coil_map = 4'b1001;
    endcase
  endfunction

  assign cmd_fwd = (cmd == 2'b10);
  assign cmd_rev = (cmd == 2'b01);

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle;
    step_fwd   = 1'b0;
    step_rev   = 1'b0;
    if (!enable) begin
      state_nxt  = S_IDLE;
      settle_nxt = '0;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (cmd_fwd) begin
            state_nxt = S_FWD;
            step_fwd  = 1'b1;
          end else if (cmd_rev) begin
            state_nxt = S_REV;
            step_rev  = 1'b1;
          end
        end
        S_FWD: begin
          if (cmd_fwd) begin
            step_fwd = 1'b1;
          end else if (cmd_rev) begin
            state_nxt  = S_SETTLE;
            settle_nxt = SET_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_REV: begin
          if (cmd_rev) begin
            step_rev = 1'b1;
          end else if (cmd_fwd) begin
            state_nxt  = S_SETTLE;
            settle_nxt = SET_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_SETTLE: begin
          if (settle > SET_ONE) begin
            settle_nxt = settle - SET_ONE;
          end else begin
            state_nxt  = S_IDLE;
            settle_nxt = '0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Position bookkeeping: phase tracks the coil pattern, sub counts steps within a degree.
  always_comb begin
    phase_nxt = phase;
    sub_nxt   = sub;
    angle_nxt = angle;
    if (step_fwd) begin
      phase_nxt = phase + 2'd1;
      if (sub == SUB_LAST) begin
        sub_nxt   = '0;
        angle_nxt = (angle == ANGLE_LAST) ? 16'd0 : angle + 16'd1;
      end else begin
        sub_nxt = sub + SUB_W'(1);
      end
    end else if (step_rev) begin
      phase_nxt = phase - 2'd1;
      if (sub == '0) begin
        sub_nxt   = SUB_LAST;
        angle_nxt = (angle == 16'd0) ? ANGLE_LAST : angle - 16'd1;
      end else begin
        sub_nxt = sub - SUB_W'(1);
      end
    end
    coil_nxt = enable ? coil_map(phase_nxt) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      phase  <= '0;
      sub    <= '0;
      settle <= '0;
      angle  <= '0;
      coil   <= '0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      sub    <= sub_nxt;
      settle <= settle_nxt;
      angle  <= angle_nxt;
      coil   <= coil_nxt;
    end
  end

  assign moving = (state == S_FWD) || (state == S_REV);

endmodule

module stepper_axis_driver #(
  parameter int STEP_DIV      = 50000,
  parameter int STEPS_PER_DEG = 8,
  parameter int SETTLE_TICKS  = 2,
  parameter int ANGLE_MAX     = 360
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  S_out_teta,
  input  logic [1:0]  S_out_fi,
  output logic [3:0]  coil_teta,
  output logic [3:0]  coil_fi,
  output logic [15:0] teta_actual,
  output logic [15:0] fi_actual,
  output logic        moving_teta,
  output logic        moving_fi
);
  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!enable || presc == CNT_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  assign tick = enable && (presc == CNT_LAST);

  stepper_axis #(
    .STEPS_PER_DEG(STEPS_PER_DEG),
    .SETTLE_TICKS (SETTLE_TICKS),
    .ANGLE_MAX    (ANGLE_MAX)
  ) u_teta (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (tick),
    .cmd   (S_out_teta),
    .coil  (coil_teta),
    .angle (teta_actual),
    .moving(moving_teta)
  );

  stepper_axis #(
    .STEPS_PER_DEG(STEPS_PER_DEG),
    .SETTLE_TICKS (SETTLE_TICKS),
    .ANGLE_MAX    (ANGLE_MAX)
  ) u_fi (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (tick),
    .cmd   (S_out_fi),
    .coil  (coil_fi),
    .angle (fi_actual),
    .moving(moving_fi)
  );

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Bench for stepper_axis_driver: position-based reference model checked every cycle,
// directed sequences with literal expectations, then randomized commands/enable/reset.

module tb_stepper_axis_driver;
  localparam int STEP_DIV = 4;
  localparam int SPD      = 2;
  localparam int SETTLE   = 2;
  localparam int AMAX     = 360;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  S_out_teta, S_out_fi;
  logic [3:0]  coil_teta, coil_fi;
  logic [15:0] teta_actual, fi_actual;
  logic        moving_teta, moving_fi;

  stepper_axis_driver #(
    .STEP_DIV(STEP_DIV), .STEPS_PER_DEG(SPD), .SETTLE_TICKS(SETTLE), .ANGLE_MAX(AMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .S_out_teta(S_out_teta), .S_out_fi(S_out_fi),
    .coil_teta(coil_teta), .coil_fi(coil_fi),
    .teta_actual(teta_actual), .fi_actual(fi_actual),
    .moving_teta(moving_teta), .moving_fi(moving_fi)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: signed step position per axis; direction -1/0/+1; remaining settle ticks.
  int   pos[2];
  int   dir[2];
  int   settle_left[2];
  int   m_cnt;
  logic m_tick;
  logic m_en;
  logic [3:0] cmap[4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

  function automatic int mod_pos(int v, int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic logic [15:0] exp_angle(int p);
    int d;
    d = (p >= 0) ? p / SPD : -((-p + SPD - 1) / SPD);
    return 16'(mod_pos(d, AMAX));
  endfunction

  function automatic logic [3:0] exp_coil(int p);
    return m_en ? cmap[mod_pos(p, 4)] : 4'b0000;
  endfunction

  function automatic void axis_update(int a, logic [1:0] c);
    int want;
    want = (c == 2'b10) ? 1 : (c == 2'b01) ? -1 : 0;
    if (!enable) begin
      dir[a] = 0;
      settle_left[a] = 0;
    end else if (m_tick) begin
      if (settle_left[a] > 0) begin
        settle_left[a]--;
      end else if (dir[a] == 0) begin
        dir[a] = want;
        pos[a] += want;
      end else if (want == 0) begin
        dir[a] = 0;
      end else if (want == dir[a]) begin
        pos[a] += want;
      end else begin
        dir[a] = 0;
        settle_left[a] = SETTLE;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_tick = 0; m_en = 0;
      for (int a = 0; a < 2; a++) begin
        pos[a] = 0; dir[a] = 0; settle_left[a] = 0;
      end
    end else begin
      m_tick = enable && (m_cnt == STEP_DIV - 1);
      m_cnt  = enable ? (m_cnt + 1) % STEP_DIV : 0;
      axis_update(0, S_out_teta);
      axis_update(1, S_out_fi);
      m_en = enable;
    end
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("coil_teta", 16'(coil_teta), 16'(exp_coil(pos[0])));
      chk("coil_fi",   16'(coil_fi),   16'(exp_coil(pos[1])));
      chk("teta_actual", teta_actual, exp_angle(pos[0]));
      chk("fi_actual",   fi_actual,   exp_angle(pos[1]));
      chk("moving_teta", 16'(moving_teta), 16'(dir[0] != 0));
      chk("moving_fi",   16'(moving_fi),   16'(dir[1] != 0));
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tick && n < 20);
    n_total++;
    if (m_tick) n_pass++;
    else $display("FAIL tick_wait: got no tick within %0d cycles", n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]  t2_coil[4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
  logic [15:0] t2_ang[4]  = '{16'd0, 16'd1, 16'd1, 16'd2};

  initial begin
    rst_n = 1'b0; enable = 1'b1; S_out_teta = 2'b00; S_out_fi = 2'b00;
    #23;
    chk("rst_coil_teta", 16'(coil_teta), 16'd0);
    chk("rst_moving_teta", 16'(moving_teta), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_coil_teta", 16'(coil_teta), 16'b1100);
    chk("init_coil_fi", 16'(coil_fi), 16'b1100);
    chk("init_teta", teta_actual, 16'd0);

    // forward run, then reversal through settle
    S_out_teta = 2'b10;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      chk("fwd_coil", 16'(coil_teta), 16'(t2_coil[i]));
      chk("fwd_angle", teta_actual, t2_ang[i]);
      chk("fwd_moving", 16'(moving_teta), 16'd1);
      chk("fwd_fi_still", 16'(coil_fi), 16'b1100);
    end
    S_out_teta = 2'b01;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      chk("settle_coil", 16'(coil_teta), 16'b1100);
      chk("settle_moving", 16'(moving_teta), 16'd0);
    end
    wait_tick();
    chk("rev_coil", 16'(coil_teta), 16'b1001);
    chk("rev_angle", teta_actual, 16'd1);
    chk("rev_moving", 16'(moving_teta), 16'd1);

    // reverse wrap below zero, then forward wrap back to zero
    S_out_teta = 2'b00; S_out_fi = 2'b01;
    do_reset();
    wait_tick();
    chk("wrap_dn_angle1", fi_actual, 16'd359);
    chk("wrap_dn_coil1", 16'(coil_fi), 16'b1001);
    wait_tick();
    chk("wrap_dn_angle2", fi_actual, 16'd359);
    chk("wrap_dn_coil2", 16'(coil_fi), 16'b0011);
    S_out_fi = 2'b10;
    for (int i = 0; i < 3; i++) wait_tick();
    wait_tick();
    chk("wrap_up_angle1", fi_actual, 16'd359);
    wait_tick();
    chk("wrap_up_angle2", fi_actual, 16'd0);
    chk("wrap_up_moving", 16'(moving_fi), 16'd1);

    // enable drop and restore
    enable = 1'b0;
    @(negedge clk);
    chk("dis_coil_fi", 16'(coil_fi), 16'd0);
    chk("dis_moving_fi", 16'(moving_fi), 16'd0);
    chk("dis_fi_kept", fi_actual, 16'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("en_coil_fi", 16'(coil_fi), 16'b1100);

    // randomized commands, enable toggles and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) S_out_teta = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) S_out_fi = 2'($urandom_range(0, 3));
      if (enable ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 5) == 0))
        enable = ~enable;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // asynchronous reset mid-cycle
    enable = 1'b1; S_out_teta = 2'b10; S_out_fi = 2'b01;
    for (int i = 0; i < 3; i++) wait_tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_coil_teta", 16'(coil_teta), 16'd0);
    chk("async_coil_fi", 16'(coil_fi), 16'd0);
    chk("async_teta", teta_actual, 16'd0);
    chk("async_fi", fi_actual, 16'd0);
    chk("async_moving", 16'({moving_teta, moving_fi}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
